crc_serial_checker: RTL and testbench

CRC_SERIAL_CHECKER -- requirements
Module: crc_serial_checker

---
 rtl/crc_serial_checker.sv | 97 +++++++++
 tb/tb_crc_serial_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_checker.sv
// Serial CRC-4 codeword checker: accepts a 12-bit {data, crc} word, clocks it MSB-first
// through an LFSR and reports the remainder. Optional error counter under CRC_ERR_COUNT_EN.
module crc_serial_checker #(
   parameter logic [3:0] POLY = 4'b0011
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_code,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic [3:0]  out_syndrome,
   output logic        out_error,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_nxt;
   logic [11:0] sreg;
   logic [3:0]  crc;
   logic [3:0]  cnt;
   logic [7:0]  data_q;
   logic        accept;
   logic        fb;

   assign accept = in_valid && in_ready;
   assign fb     = crc[3] ^ sreg[11];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cnt == 4'd0) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Data is kept separately from the shift register, which is consumed as it shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg   <= 12'h000;
         crc    <= 4'h0;
         cnt    <= 4'd0;
         data_q <= 8'h00;
      end else if (accept) begin
         sreg   <= in_code;
         crc    <= 4'h0;
         cnt    <= 4'd11;
         data_q <= in_code[11:4];
      end else if (state == SHIFT) begin
         crc  <= {crc[2:0], 1'b0} ^ (fb ? POLY : 4'h0);
         sreg <= {sreg[10:0], 1'b0};
         if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
   end

   // Result is only presented while DONE, so intermediate LFSR values never leak out.
   assign out_data     = (state == DONE) ? data_q : 8'h00;
   assign out_syndrome = (state == DONE) ? crc : 4'h0;
   assign out_error    = |out_syndrome;

`ifdef CRC_ERR_COUNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 8'h00;
      end else if (out_valid && out_ready && out_error && (err_q != 8'hFF)) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_crc_serial_checker.sv
// Directed plus randomized bench for crc_serial_checker; expected syndromes come from
// polynomial long division by g = x^4+x+1.
module tb_crc_serial_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_code;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [3:0]  out_syndrome;
   logic        out_error;
   logic [7:0]  err_count;

   int passed = 0;
   int total  = 0;
   int exp_err = 0;

   crc_serial_checker dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_code(in_code),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_syndrome(out_syndrome),
      .out_error(out_error),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Remainder of a 16-bit polynomial modulo g (0x13) by long division.
   function automatic logic [3:0] pmod(input logic [15:0] v_in);
      logic [15:0] v;
      v = v_in;
      for (int b = 15; b >= 4; b--) begin
         if (v[b]) v = v ^ (16'h0013 << (b - 4));
      end
      return v[3:0];
   endfunction

   // The serial LFSR yields code * x^4 mod g.
   function automatic logic [3:0] ref_syn(input logic [11:0] code);
      return pmod({code, 4'h0});
   endfunction

   function automatic logic [11:0] make_valid(input logic [7:0] d);
      return {d, pmod({4'h0, d, 4'h0})};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic note_handshake(input logic err);
`ifdef CRC_ERR_COUNT_EN
      if (err && exp_err < 255) exp_err++;
`endif
   endtask

   task automatic do_accept(input logic [11:0] code);
      @(negedge clk);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_code  = code;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_code  = 12'($urandom);
   endtask

   task automatic wait_result(input logic [11:0] code);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 32'(n), 32'd12);
      check("out_data", 32'(out_data), 32'(code[11:4]));
      check("out_syndrome", 32'(out_syndrome), 32'(ref_syn(code)));
      check("out_error", 32'(out_error), 32'(ref_syn(code) != 4'h0));
   endtask

   task automatic release_result();
      logic err;
      err = out_error;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      note_handshake(err);
      check("out_valid_after_hs", 32'(out_valid), 32'd0);
      check("in_ready_after_hs", 32'(in_ready), 32'd1);
      check("err_count", 32'(err_count), 32'(exp_err));
   endtask

   initial begin
      logic [11:0] code;
      logic [11:0] burst;
      logic [7:0]  hold_data;
      logic [3:0]  hold_syn;
      int          len;
      int          pos;
      int          seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = 12'h000;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
      check("rst_out_error", 32'(out_error), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed codewords: valid, single-bit error, 4-bit burst.
      do_accept(12'h013);
      wait_result(12'h013);
      check("h013_syndrome", 32'(out_syndrome), 32'h0);
      release_result();

      do_accept(12'h012);
      wait_result(12'h012);
      check("h012_syndrome", 32'(out_syndrome), 32'h3);
      release_result();

      do_accept(12'h01C);
      wait_result(12'h01C);
      check("h01C_syndrome", 32'(out_syndrome), 32'h2);
      check("h01C_error", 32'(out_error), 32'd1);
      release_result();

      // Backpressure: result must hold while a second offer is ignored.
      code = make_valid(8'hA5) ^ 12'h040;
      do_accept(code);
      wait_result(code);
      hold_data = out_data;
      hold_syn  = out_syndrome;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_code  = 12'($urandom);
         @(posedge clk);
         #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_data", 32'(out_data), 32'(hold_data));
         check("bp_out_syndrome", 32'(out_syndrome), 32'(hold_syn));
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result();

      // Reset in the middle of shifting discards the codeword.
      do_accept(12'h5A7);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_err = 0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_syndrome", 32'(out_syndrome), 32'd0);
      check("midrst_out_error", 32'(out_error), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("midrst_no_result", 32'(seen), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      do_accept(12'h000);
      wait_result(12'h000);
      check("h000_syndrome", 32'(out_syndrome), 32'h0);
      release_result();

      // Random valid codewords, some with result acceptance overlapping DONE entry.
      for (int i = 0; i < 10; i++) begin
         code = make_valid(8'($urandom));
         do_accept(code);
         wait_result(code);
         check("rand_valid_error", 32'(out_error), 32'd0);
         release_result();
      end

      // 300 random bursts of length 1..4: every one must be flagged.
      for (int i = 0; i < 300; i++) begin
         len   = $urandom_range(1, 4);
         pos   = $urandom_range(0, 12 - len);
         burst = (12'(1) << (len - 1)) | 12'(1) | (12'($urandom) & ((12'(1) << len) - 12'(1)));
         burst = burst << pos;
         code  = make_valid(8'($urandom)) ^ burst;
         do_accept(code);
         wait_result(code);
         check("burst_error", 32'(out_error), 32'd1);
         release_result();
      end
`ifdef CRC_ERR_COUNT_EN
      check("err_count_saturated", 32'(err_count), 32'hFF);
`else
      check("err_count_disabled", 32'(err_count), 32'h00);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
